// File: rtl/lbr_filtered_unit_pkg.sv
// lbr_filtered_unit_pkg: shared encodings and status layout for the filtered last-branch-record unit
package lbr_filtered_unit_pkg;
  typedef enum logic [1:0] {REQ_IDLE, REQ_CONFIG, REQ_READ, REQ_CLEAR} lbr_req_e;
  typedef enum logic [1:0] {SEL_PC4, SEL_BRANCH, SEL_JAL, SEL_JALR} pc_sel_e;
  localparam int MASK_BRANCH = 0;
  localparam int MASK_JAL = 1;
  localparam int MASK_JALR = 2;
  localparam logic [2:0] MASK_RESET = 3'b111;
  typedef struct packed {
    logic overflow;
    logic frozen;
    logic freeze_en;
    logic [2:0] mask;
  } lbr_flags_t;
endpackage

// File: rtl/lbr_record_ram.sv
// lbr_record_ram: record storage with one write port, one combinational read port and a synchronous clear
module lbr_record_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clock or negedge reset)
    if (!reset) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (clear) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/lbr_filtered_unit.sv
// lbr_filtered_unit: filtered last-branch-record buffer with freeze, overflow, clear and registered newest-first reads
module lbr_filtered_unit
  import lbr_filtered_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int LOG2_DEPTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic stall,
  input  logic [1:0] next_PC_sel,
  input  logic [DATA_WIDTH-1:0] PC_address,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic [DATA_WIDTH-1:0] JAL_target,
  input  logic [DATA_WIDTH-1:0] JALR_target,
  input  logic [1:0] lbrReq,
  input  logic [DATA_WIDTH-1:0] RW_address,
  input  logic [DATA_WIDTH-1:0] ALU_result,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic output_valid
);
  logic [LOG2_DEPTH-1:0] wr_ptr, rd_idx, k;
  logic [LOG2_DEPTH:0] count;
  lbr_flags_t flags;
  logic [DATA_WIDTH-1:0] tgt, rd_data;
  logic [2*DATA_WIDTH-1:0] rec;
  logic type_ok, want, full, drop, cap, clr;
  always_comb begin
    tgt = next_PC_sel == SEL_BRANCH ? branch_target : next_PC_sel == SEL_JAL ? JAL_target : JALR_target;
    type_ok = (next_PC_sel == SEL_BRANCH && flags.mask[MASK_BRANCH]) ||
              (next_PC_sel == SEL_JAL && flags.mask[MASK_JAL]) ||
              (next_PC_sel == SEL_JALR && flags.mask[MASK_JALR]);
    full = count == (LOG2_DEPTH+1)'(DEPTH);
    clr = lbrReq == REQ_CLEAR;
    want = !stall && type_ok && !flags.frozen && !clr;
    drop = want && full && flags.freeze_en;
    cap = want && !drop;
    k = RW_address[LOG2_DEPTH:1];
    rd_idx = wr_ptr - 1'b1 - k;
    rd_data = RW_address < DATA_WIDTH'(2*DEPTH) ?
                ({1'b0, k} < count ? (RW_address[0] ? rec[DATA_WIDTH-1:0] : rec[2*DATA_WIDTH-1:DATA_WIDTH]) : '0) :
              RW_address == DATA_WIDTH'(2*DEPTH) ? DATA_WIDTH'({count, flags}) : '0;
  end
  lbr_record_ram #(.WIDTH(2*DATA_WIDTH), .DEPTH(DEPTH), .AW(LOG2_DEPTH)) u_ram (
    .clock(clock),
    .reset(reset),
    .clear(clr),
    .we(cap),
    .waddr(wr_ptr),
    .wdata({PC_address, tgt}),
    .raddr(rd_idx),
    .rdata(rec)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      count <= '0;
      flags <= '{overflow: 1'b0, frozen: 1'b0, freeze_en: 1'b0, mask: MASK_RESET};
      output_data <= '0;
      output_valid <= 1'b0;
    end else begin
      output_valid <= lbrReq == REQ_READ;
      if (lbrReq == REQ_READ) output_data <= rd_data;
      if (lbrReq == REQ_CONFIG) begin
        flags.mask <= ALU_result[2:0];
        flags.freeze_en <= ALU_result[3];
      end
      if (clr) begin
        wr_ptr <= '0;
        count <= '0;
        flags.overflow <= 1'b0;
        flags.frozen <= 1'b0;
      end else begin
        if (cap) begin
          wr_ptr <= wr_ptr + 1'b1;
          count <= full ? count : count + 1'b1;
        end
        if (want && full) flags.overflow <= 1'b1;
        if (drop) flags.frozen <= 1'b1;
      end
    end
endmodule

// File: tb/tb_lbr_filtered_unit.sv
// tb_lbr_filtered_unit: directed tables plus randomized traffic against a queue-based reference model
module tb_lbr_filtered_unit;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int LD = 3;
  logic clock = 0, reset = 0, stall = 0;
  logic [1:0] next_PC_sel = 0, lbrReq = 0;
  logic [DW-1:0] PC_address = 0, branch_target = 0, JAL_target = 0, JALR_target = 0, RW_address = 0, ALU_result = 0;
  logic [DW-1:0] output_data;
  logic output_valid;
  always #5 clock = ~clock;
  lbr_filtered_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LOG2_DEPTH(LD)) dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .next_PC_sel(next_PC_sel),
    .PC_address(PC_address),
    .branch_target(branch_target),
    .JAL_target(JAL_target),
    .JALR_target(JALR_target),
    .lbrReq(lbrReq),
    .RW_address(RW_address),
    .ALU_result(ALU_result),
    .output_data(output_data),
    .output_valid(output_valid)
  );
  int n_pass = 0, n_tot = 0;
  logic [31:0] q[$];
  logic m_ovf, m_frz, m_fen, m_valid;
  logic [2:0] m_mask;
  logic [15:0] m_data;
  typedef struct {
    logic [15:0] addr;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[15];
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic mdl_reset;
    q.delete();
    m_ovf = 0;
    m_frz = 0;
    m_fen = 0;
    m_mask = 3'b111;
    m_data = 0;
    m_valid = 0;
  endtask
  function automatic logic [15:0] mread(input logic [15:0] a);
    int k;
    if (a < 2*DEPTH) begin
      k = a / 2;
      if (k < q.size()) return a[0] ? q[k][15:0] : q[k][31:16];
      return 16'h0;
    end
    if (a == 2*DEPTH) return 16'(q.size()*64 + m_ovf*32 + m_frz*16 + m_fen*8 + m_mask);
    return 16'h0;
  endfunction
  task automatic cyc(input logic [1:0] sel, input logic [15:0] pc, input logic [15:0] bt, input logic [15:0] jt,
                     input logic [15:0] jrt, input logic st, input logic [1:0] req, input logic [15:0] addr,
                     input logic [15:0] alu);
    logic ok;
    logic [15:0] t;
    next_PC_sel = sel;
    PC_address = pc;
    branch_target = bt;
    JAL_target = jt;
    JALR_target = jrt;
    stall = st;
    lbrReq = req;
    RW_address = addr;
    ALU_result = alu;
    m_valid = req == 2'b10;
    if (m_valid) m_data = mread(addr);
    ok = (sel == 2'd1 && m_mask[0]) || (sel == 2'd2 && m_mask[1]) || (sel == 2'd3 && m_mask[2]);
    t = sel == 2'd1 ? bt : sel == 2'd2 ? jt : jrt;
    if (req == 2'b11) begin
      q.delete();
      m_ovf = 0;
      m_frz = 0;
    end else if (!st && ok && !m_frz) begin
      if (q.size() == DEPTH) begin
        m_ovf = 1;
        if (m_fen) m_frz = 1;
        else begin
          void'(q.pop_back());
          q.push_front({pc, t});
        end
      end else q.push_front({pc, t});
    end
    if (req == 2'b01) begin
      m_mask = alu[2:0];
      m_fen = alu[3];
    end
    @(posedge clock);
    #1;
    chk("valid", {15'b0, output_valid}, {15'b0, m_valid});
    chk("data", output_data, m_data);
  endtask
  task automatic cap(input logic [1:0] sel, input logic [15:0] pc, input logic [15:0] tgt, input logic st);
    cyc(sel, pc, sel == 2'd1 ? tgt : 16'($urandom), sel == 2'd2 ? tgt : 16'($urandom),
        sel == 2'd3 ? tgt : 16'($urandom), st, 2'b00, 16'($urandom), 16'($urandom));
  endtask
  task automatic req_only(input logic [1:0] req, input logic [15:0] addr, input logic [15:0] alu);
    cyc(2'b00, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, req, addr, alu);
  endtask
  task automatic rdx(input string name, input logic [15:0] addr, input logic [15:0] exp);
    req_only(2'b10, addr, 16'h0);
    chk(name, output_data, exp);
  endtask
  initial begin
    mdl_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_data", output_data, 16'h0);
    chk("rst_valid", {15'b0, output_valid}, 16'h0);
    reset = 1;
    for (int i = 0; i < 8; i++)
      cap(i % 2 == 0 ? 2'd2 : 2'd3, 16'(i), i % 2 == 0 ? 16'(1 << i) : 16'(16'hffff >> i), i == 3);
    tbl = '{'{16'd0, 16'h0007}, '{16'd1, 16'h01ff}, '{16'd2, 16'h0006}, '{16'd3, 16'h0040},
            '{16'd4, 16'h0005}, '{16'd5, 16'h07ff}, '{16'd6, 16'h0004}, '{16'd7, 16'h0010},
            '{16'd8, 16'h0002}, '{16'd9, 16'h0004}, '{16'd13, 16'h0001}, '{16'd14, 16'h0000},
            '{16'd16, 16'h01c7}, '{16'd17, 16'h0000}, '{16'hffff, 16'h0000}};
    for (int i = 0; i < 15; i++) rdx($sformatf("t1_addr_%0h", tbl[i].addr), tbl[i].addr, tbl[i].exp);
    req_only(2'b11, 16'h0, 16'h0);
    for (int i = 0; i < 10; i++) cap(2'd2, 16'(i), 16'(16'h100 + i), 1'b0);
    rdx("wrap_addr0", 16'd0, 16'h0009);
    rdx("wrap_addr14", 16'd14, 16'h0002);
    rdx("wrap_status", 16'd16, 16'h0227);
    req_only(2'b11, 16'h0, 16'h0);
    req_only(2'b01, 16'h0, 16'h000a);
    for (int i = 0; i < 10; i++) begin
      cap(2'd2, 16'(i), 16'(16'h200 + i), 1'b0);
      cap(2'd3, 16'(16'h100 + i), 16'(16'h300 + i), 1'b0);
    end
    rdx("frz_addr0", 16'd0, 16'h0007);
    rdx("frz_addr1", 16'd1, 16'h0207);
    rdx("frz_addr14", 16'd14, 16'h0000);
    rdx("frz_status", 16'd16, 16'h023a);
    req_only(2'b01, 16'h0, 16'h0002);
    cap(2'd2, 16'h0077, 16'h0078, 1'b0);
    rdx("stay_frozen_addr0", 16'd0, 16'h0007);
    rdx("stay_frozen_status", 16'd16, 16'h0232);
    cyc(2'd2, 16'h0055, 16'h0, 16'h0056, 16'h0, 1'b0, 2'b11, 16'h0, 16'h0);
    rdx("clr_status", 16'd16, 16'h0002);
    rdx("clr_addr0", 16'd0, 16'h0000);
    rdx("lat_status", 16'd16, 16'h0002);
    req_only(2'b00, 16'h0, 16'h0);
    chk("lat_valid_drop", {15'b0, output_valid}, 16'h0);
    chk("lat_hold", output_data, 16'h0002);
    rdx("oob_17", 16'd17, 16'h0000);
    rdx("oob_pre", 16'd16, 16'h0002);
    rdx("oob_ffff", 16'hffff, 16'h0000);
    req_only(2'b01, 16'h0, 16'h0007);
    for (int i = 0; i < 5; i++) cap(2'd1, 16'(16'h40 + i), 16'(16'h80 + i), 1'b0);
    req_only(2'b10, 16'd0, 16'h0);
    chk("pre_rst_data", output_data, 16'h0044);
    reset = 0;
    #2;
    chk("mid_rst_data", output_data, 16'h0);
    chk("mid_rst_valid", {15'b0, output_valid}, 16'h0);
    mdl_reset();
    #2;
    reset = 1;
    @(posedge clock);
    #1;
    rdx("post_rst_status", 16'd16, 16'h0007);
    rdx("post_rst_addr0", 16'd0, 16'h0000);
    repeat (1500) begin
      int r;
      logic [1:0] req;
      r = $urandom_range(0, 99);
      req = r < 55 ? 2'b00 : r < 85 ? 2'b10 : r < 96 ? 2'b01 : 2'b11;
      cyc(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
          $urandom_range(0, 3) == 0, req,
          $urandom_range(0, 9) == 0 ? 16'($urandom) : 16'($urandom_range(0, 17)), 16'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
